fm_discriminator: RTL and testbench
===================================

Name: fm_discriminator

Overview:
- Consumes the CORDIC stage's AXI-Stream output: 64-bit beats, [31:0] unsigned magnitude, [63:32] phase angle in full-scale units (2^32 = one turn).
- Produces FM-demodulated audio as follows:
  - differences consecutive phase angles with modulo-2^32 wrap;
  - gates the result with a magnitude squelch;
  - decimates by a boxcar average of 2^C_DECIM_LOG2 samples;
  - emits signed audio samples on a 32-bit AXI-Stream.
- Sits directly downstream of the CORDIC, ahead of the audio FIFO/DAC path.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 64: input beat width; fixed layout {angle[31:0], mag[31:0]}.
- C_M00_AXIS_TDATA_WIDTH, 32: output beat width.
- C_DECIM_LOG2, 3: log2 of the decimation factor D (D=8). Legal range 0..8.
- C_OUT_WIDTH, 16: audio sample width. Must be <= C_M00_AXIS_TDATA_WIDTH.

Ports:
- s00_axis_aclk  in  1  single clock.
- s00_axis_areset  in  1  asynchronous, active-high reset.
- s00_axis_tvalid  in  1  input beat valid.
- s00_axis_tlast  in  1  end of packet/burst.
- s00_axis_tdata  in  64  [31:0] magnitude, [63:32] angle.
- s00_axis_tstrb  in  8  ignored.
- s00_axis_tready  out  1  input ready.
- squelch_thresh  in  32  magnitude threshold; quasi-static.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tvalid  out  1  output sample valid.
- m00_axis_tlast  out  1  output sample closes a packet.
- m00_axis_tdata  out  32  [C_OUT_WIDTH-1:0] signed audio; upper bits are sign extension.
- m00_axis_tstrb  out  4  constant 4'hF.

Behaviour:
- Reset (asynchronous, active-high). On assertion:
  - m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0;
  - internal: acc=0, cnt=0, prev_angle=0, state=FIRST.
  - Reset mid-window discards the partial window and any pending output.
- Handshake:
  - accept = s00_axis_tvalid & s00_axis_tready.
  - s00_axis_tready = !m00_axis_tvalid | m00_axis_tready (single output register; combinational ready).
  - An output beat completes on m00_axis_tvalid & m00_axis_tready.
  - m00_axis_tvalid, tdata and tlast are held stable while tready=0.
- State machine, 2 states:
  - FIRST: no valid prev_angle. On accept: delta_eff=0, prev_angle<=angle, go to RUN. Accumulation and the counter still advance.
  - RUN: on accept: delta=angle-prev_angle, computed as 32-bit modular subtract interpreted signed, so wrap is automatic. Example: 0xF000_0000 -> 0x1000_0000 gives +0x2000_0000. Then prev_angle<=angle.
  - Any accept with tlast=1: next state is FIRST.
- Squelch: if mag < squelch_thresh (unsigned compare), delta_eff=0; otherwise delta_eff=delta. prev_angle updates regardless.
- Accumulator:
  - acc is signed, width 32+C_DECIM_LOG2; sum = acc + sign-extended delta_eff.
  - cnt counts 0..D-1.
  - Window close occurs on accept when cnt==D-1 or tlast=1.
- At window close:
  - m00_axis_tdata <= sign-extend of sum >>> (32+C_DECIM_LOG2-C_OUT_WIDTH). This is an arithmetic shift, rounding toward -inf, keeping the top C_OUT_WIDTH bits.
  - m00_axis_tlast <= s00_axis_tlast; m00_axis_tvalid<=1.
  - acc<=0, cnt<=0.
- Not window close: acc<=sum, cnt<=cnt+1.
- Partial window on tlast: divided by D, not renormalised.
- Latency: m00_axis_tvalid rises the clock after the window-closing accept.
- Simultaneous output handshake and window close in the same cycle: the new sample replaces the old one and tvalid stays 1. No bubble, no loss.
- D=1 (C_DECIM_LOG2=0): every accept produces one output.
- tstrb is constant 4'hF and does not depend on reset.

Decomposition:
- Package fm_pkg holds:
  - localparams for input field offsets: ANGLE_LSB=32, MAG_LSB=0, FIELD_W=32;
  - typedefs angle_t (logic [31:0]) and mag_t (logic [31:0]);
  - the state enum {FIRST, RUN};
  - a shared function for the output-shift amount.
- Single module; no sub-module. The output register is too small to justify a separate skid buffer.

Test Plan:
- Constant increment: angle += 0x0100_0000 per beat, mag=1000, thresh=10, 24 beats, tready=1.
  - Outputs are 224 (first window, first delta forced 0), 256, 256.
  - tlast=0 on all outputs.
- Negative increment plus wrap: angle starts at 0x0800_0000 and steps by -0x0100_0000, crossing 0.
  - Steady-state outputs are -256 (tdata 0xFFFF_FF00).
  - No glitch at the wrap.
- Squelch: same stimulus as the first scenario with mag=5, thresh=10.
  - All outputs are 0.
  - When mag is raised mid-window, that window's sample reflects only the unsquelched deltas.
- Backpressure: hold m00_axis_tready=0 while an output is pending.
  - s00_axis_tready=0 and tdata/tvalid stay stable.
  - Releasing tready gives exactly one output handshake, and input resumes the same cycle.
- tlast mid-window: tlast on the 3rd beat of a window, increment 0x0100_0000 steady state.
  - Output = (3*2^24)>>>19 = 96, with m00_axis_tlast=1.
  - The next beat's delta is 0, and the next window restarts at cnt=0.
- Async reset mid-window: assert s00_axis_areset between clock edges after 5 beats.
  - Outputs drop to 0 immediately.
  - After release, the first window's output matches the first scenario (224).

Source files
------------

// File: rtl/fm_pkg.sv
// Shared definitions for the FM discriminator: input beat layout,
// sample types, FSM states and the output scaling helper.
package fm_pkg;

    localparam int ANGLE_LSB = 32;
    localparam int MAG_LSB   = 0;
    localparam int FIELD_W   = 32;

    typedef logic [FIELD_W-1:0] angle_t;
    typedef logic [FIELD_W-1:0] mag_t;

    typedef enum logic {
        FIRST,
        RUN
    } state_t;

    // Right shift that keeps the top out_w bits of the window sum.
    function automatic int out_shift(input int decim_log2, input int out_w);
        return FIELD_W + decim_log2 - out_w;
    endfunction

endpackage

// File: rtl/fm_discriminator.sv
// FM discriminator: phase differencing, magnitude squelch and
// boxcar decimation of CORDIC output into signed audio samples.
module fm_discriminator
    import fm_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 64,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int C_DECIM_LOG2           = 3,
    parameter int C_OUT_WIDTH            = 16
) (
    input  logic                                s00_axis_aclk,
    input  logic                                s00_axis_areset,
    input  logic                                s00_axis_tvalid,
    input  logic                                s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
    output logic                                s00_axis_tready,
    input  logic [FIELD_W-1:0]                  squelch_thresh,
    input  logic                                m00_axis_tready,
    output logic                                m00_axis_tvalid,
    output logic                                m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

    localparam int ACC_W = FIELD_W + C_DECIM_LOG2;
    localparam int CNT_W = (C_DECIM_LOG2 > 0) ? C_DECIM_LOG2 : 1;
    localparam int SHIFT = out_shift(C_DECIM_LOG2, C_OUT_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << C_DECIM_LOG2) - 1);

    state_t state;
    state_t state_nxt;

    angle_t angle;
    angle_t prev_angle;
    mag_t   mag;

    logic signed [FIELD_W-1:0]     delta;
    logic signed [FIELD_W-1:0]     delta_eff;
    logic signed [ACC_W-1:0]       delta_ext;
    logic signed [ACC_W-1:0]       acc;
    logic signed [ACC_W-1:0]       sum;
    logic signed [C_OUT_WIDTH-1:0] sample;
    logic [CNT_W-1:0]              cnt;

    logic accept;
    logic close;
    logic squelched;
    logic unused_tstrb;

    assign angle  = s00_axis_tdata[ANGLE_LSB +: FIELD_W];
    assign mag    = s00_axis_tdata[MAG_LSB +: FIELD_W];

    // A single output register: input may advance whenever it is free
    // or being drained this cycle.
    assign s00_axis_tready = !m00_axis_tvalid || m00_axis_tready;
    assign accept          = s00_axis_tvalid && s00_axis_tready;

    assign m00_axis_tstrb  = '1;
    assign unused_tstrb    = ^s00_axis_tstrb;

    // Phase difference, squelch gate, running window sum and scaling.
    always_comb begin
        delta     = signed'(angle - prev_angle);
        squelched = (mag < squelch_thresh);
        delta_eff = delta;
        if (state == FIRST || squelched) begin
            delta_eff = '0;
        end
        delta_ext = ACC_W'(delta_eff);
        sum       = acc + delta_ext;
        close     = s00_axis_tlast || (cnt == CNT_LAST);
        sample    = C_OUT_WIDTH'(sum >>> SHIFT);
    end

    // Next state: a packet end forgets the reference phase.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = s00_axis_tlast ? FIRST : RUN;
        end
    end

    // State register.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state <= FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    // Reference phase, accumulator and window counter.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            prev_angle <= '0;
            acc        <= '0;
            cnt        <= '0;
        end else if (accept) begin
            prev_angle <= angle;
            if (close) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Output register: a closing window overwrites any sample leaving
    // this cycle, otherwise a completed handshake empties it.
    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
        end else if (accept && close) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tlast  <= s00_axis_tlast;
            m00_axis_tdata  <= C_M00_AXIS_TDATA_WIDTH'(sample);
        end else if (m00_axis_tvalid && m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fm_discriminator.sv
// Scoreboard bench for fm_discriminator: a reference model queues
// expected samples on each accepted beat; a monitor pops and compares.
module tb_fm_discriminator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tstrb = 8'hFF;
    logic        s_tready;
    logic [31:0] thresh = 32'd10;
    logic        m_tready = 1'b1;
    logic        m_tvalid;
    logic        m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;

    int n_checks = 0;
    int n_pass = 0;
    int hs_count = 0;

    logic [31:0] exp_data[$];
    logic        exp_last[$];
    logic [31:0] got[$];
    logic        got_last[$];

    logic        mdl_first;
    logic [31:0] mdl_prev;
    longint      mdl_acc;
    int          mdl_cnt;

    fm_discriminator dut (
        .s00_axis_aclk   (clk),
        .s00_axis_areset (rst),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tlast  (s_tlast),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tstrb  (s_tstrb),
        .s00_axis_tready (s_tready),
        .squelch_thresh  (thresh),
        .m00_axis_tready (m_tready),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tlast  (m_tlast),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb)
    );

    always #5 clk = ~clk;

    // Compare every completed output handshake with the scoreboard.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) begin
            n_checks++;
            if (exp_data.size() == 0) begin
                $display("FAIL out_unexpected got=%h none expected", m_tdata);
            end else begin
                logic [31:0] ed;
                logic        el;
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                if (m_tdata !== ed || m_tlast !== el)
                    $display("FAIL out_sample got=%h/%b want=%h/%b",
                             m_tdata, m_tlast, ed, el);
                else
                    n_pass++;
            end
            got.push_back(m_tdata);
            got_last.push_back(m_tlast);
            hs_count++;
        end
    end

    task automatic model_reset();
        mdl_first = 1'b1;
        mdl_prev  = '0;
        mdl_acc   = 0;
        mdl_cnt   = 0;
        exp_data.delete();
        exp_last.delete();
        got.delete();
        got_last.delete();
    endtask

    task automatic model_accept(input logic [31:0] ang,
                                input logic [31:0] mg,
                                input logic lst);
        longint d;
        longint q;
        logic [31:0] dd;
        dd = ang - mdl_prev;
        d  = mdl_first ? 0 : longint'($signed(dd));
        if (mg < thresh) d = 0;
        mdl_prev  = ang;
        mdl_first = lst;
        mdl_acc   = mdl_acc + d;
        if (lst || mdl_cnt == 7) begin
            q = mdl_acc / 524288;
            if (mdl_acc < 0 && (mdl_acc % 524288) != 0) q = q - 1;
            exp_data.push_back(32'(q));
            exp_last.push_back(lst);
            mdl_acc = 0;
            mdl_cnt = 0;
        end else begin
            mdl_cnt++;
        end
    endtask

    task automatic send(input logic [31:0] ang, input logic [31:0] mg,
                        input logic lst, output int waits);
        s_tvalid = 1'b1;
        s_tdata  = {ang, mg};
        s_tlast  = lst;
        waits    = 0;
        while (1) begin
            @(negedge clk);
            if (s_tready) begin
                model_accept(ang, mg, lst);
                break;
            end
            waits++;
            if (waits > 1000) begin
                n_checks++;
                $display("FAIL send_timeout got=no_accept want=accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic ramp(inout logic [31:0] a, input logic [31:0] step,
                        input logic [31:0] mg, input int n,
                        input int last_idx);
        int w;
        for (int i = 0; i < n; i++) begin
            send(a, mg, (i == last_idx), w);
            a = a + step;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_got(input string name, input int idx,
                             input logic [31:0] want);
        n_checks++;
        if (idx >= got.size())
            $display("FAIL %s got=missing want=%h", name, want);
        else if (got[idx] !== want)
            $display("FAIL %s got=%h want=%h", name, got[idx], want);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        n_checks += 5;
        if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid got=%b want=0", m_tvalid);
        else n_pass++;
        if (m_tlast !== 1'b0) $display("FAIL rst_tlast got=%b want=0", m_tlast);
        else n_pass++;
        if (m_tdata !== 32'h0) $display("FAIL rst_tdata got=%h want=0", m_tdata);
        else n_pass++;
        if (s_tready !== 1'b1) $display("FAIL rst_s_tready got=%b want=1", s_tready);
        else n_pass++;
        if (m_tstrb !== 4'hF) $display("FAIL rst_tstrb got=%h want=f", m_tstrb);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_constant();
        logic [31:0] a;
        do_reset();
        a = 32'h0;
        ramp(a, 32'h0100_0000, 32'd1000, 24, -1);
        drain();
        check_got("const_w0", 0, 32'd224);
        check_got("const_w1", 1, 32'd256);
        check_got("const_w2", 2, 32'd256);
    endtask

    task automatic test_negative_wrap();
        logic [31:0] a;
        do_reset();
        a = 32'h0800_0000;
        ramp(a, 32'hFF00_0000, 32'd1000, 24, -1);
        drain();
        check_got("neg_w0", 0, 32'hFFFF_FF20);
        check_got("neg_w1", 1, 32'hFFFF_FF00);
        check_got("neg_w2", 2, 32'hFFFF_FF00);
    endtask

    task automatic test_squelch();
        logic [31:0] a;
        do_reset();
        a = 32'h0;
        ramp(a, 32'h0100_0000, 32'd5, 16, -1);
        drain();
        check_got("sq_w0", 0, 32'd0);
        check_got("sq_w1", 1, 32'd0);
        do_reset();
        a = 32'h0;
        ramp(a, 32'h0100_0000, 32'd5, 12, -1);
        ramp(a, 32'h0100_0000, 32'd1000, 4, -1);
        drain();
        check_got("sq_raise", 1, 32'd128);
    endtask

    task automatic test_backpressure();
        logic [31:0] a;
        int w;
        int hs0;
        do_reset();
        m_tready = 1'b0;
        a = 32'h0;
        ramp(a, 32'h0100_0000, 32'd1000, 8, -1);
        s_tvalid = 1'b1;
        s_tdata  = {a, 32'd1000};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks += 3;
            if (s_tready !== 1'b0) $display("FAIL bp_s_tready got=%b want=0", s_tready);
            else n_pass++;
            if (m_tvalid !== 1'b1) $display("FAIL bp_tvalid got=%b want=1", m_tvalid);
            else n_pass++;
            if (m_tdata !== 32'd224) $display("FAIL bp_tdata got=%h want=%h", m_tdata, 32'd224);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        hs0 = hs_count;
        m_tready = 1'b1;
        send(a, 32'd1000, 1'b0, w);
        n_checks += 3;
        if (w !== 0) $display("FAIL bp_resume got=%0d want=0 wait cycles", w);
        else n_pass++;
        if (hs_count !== hs0 + 1) $display("FAIL bp_handshakes got=%0d want=%0d", hs_count - hs0, 1);
        else n_pass++;
        if (m_tvalid !== 1'b0) $display("FAIL bp_tvalid_drop got=%b want=0", m_tvalid);
        else n_pass++;
    endtask

    task automatic test_tlast();
        logic [31:0] a;
        do_reset();
        a = 32'h0;
        ramp(a, 32'h0100_0000, 32'd1000, 8, -1);
        ramp(a, 32'h0100_0000, 32'd1000, 3, 2);
        ramp(a, 32'h0100_0000, 32'd1000, 8, -1);
        drain();
        check_got("tlast_part", 1, 32'd96);
        check_got("tlast_after", 2, 32'd224);
        n_checks++;
        if (got_last.size() < 2 || got_last[1] !== 1'b1)
            $display("FAIL tlast_flag got=%b want=1",
                     (got_last.size() < 2) ? 1'bx : got_last[1]);
        else
            n_pass++;
    endtask

    task automatic test_async_reset();
        logic [31:0] a;
        do_reset();
        a = 32'h0;
        ramp(a, 32'h0100_0000, 32'd1000, 13, -1);
        n_checks++;
        if (m_tdata !== 32'd224) $display("FAIL ar_before got=%h want=%h", m_tdata, 32'd224);
        else n_pass++;
        #3;
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (m_tvalid !== 1'b0) $display("FAIL ar_tvalid got=%b want=0", m_tvalid);
        else n_pass++;
        if (m_tdata !== 32'h0) $display("FAIL ar_tdata got=%h want=0", m_tdata);
        else n_pass++;
        if (m_tlast !== 1'b0) $display("FAIL ar_tlast got=%b want=0", m_tlast);
        else n_pass++;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        a = 32'h4000_0000;
        ramp(a, 32'h0100_0000, 32'd1000, 8, -1);
        drain();
        check_got("ar_first", 0, 32'd224);
    endtask

    initial begin
        test_reset();
        test_constant();
        test_negative_wrap();
        test_squelch();
        test_backpressure();
        test_tlast();
        test_async_reset();
        drain();
        n_checks++;
        if (exp_data.size() != 0)
            $display("FAIL sb_empty got=%0d want=0 pending", exp_data.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
